// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter.
// Holds the unit index constants, the unit count, the register-number
// and data widths, and a helper that steps a unit index forward with
// wrap-around.
package wb_arbiter_pkg;

  localparam int NUM_UNITS = 5;
  localparam int UNIT_W    = 3;
  localparam int RN_W      = 6;
  localparam int DATA_W    = 64;

  localparam logic [UNIT_W-1:0] ALU1    = 3'd0;
  localparam logic [UNIT_W-1:0] ALU2    = 3'd1;
  localparam logic [UNIT_W-1:0] ADVINT  = 3'd2;
  localparam logic [UNIT_W-1:0] MEMUNIT = 3'd3;
  localparam logic [UNIT_W-1:0] BRANCH  = 3'd4;

  // Unit that follows u in arbitration order, wrapping branch -> alu1.
  function automatic logic [UNIT_W-1:0] next_unit(input logic [UNIT_W-1:0] u);
    return (u == 3'(NUM_UNITS - 1)) ? ALU1 : u + 3'd1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// rr_picker: returns the first set bit of a NUM_UNITS-wide request vector
// at or after a start index, wrapping around.
// Ports:
//   req_i    request vector, bit n = unit n
//   start_i  first index to consider (must be < NUM_UNITS)
//   found_o  at least one request bit is set
//   idx_o    index of the selected request (0 when found_o=0)
module rr_picker
  import wb_arbiter_pkg::*;
(
  input  logic [NUM_UNITS-1:0] req_i,
  input  logic [UNIT_W-1:0]    start_i,
  output logic                 found_o,
  output logic [UNIT_W-1:0]    idx_o
);

  // Scan from the farthest offset down to offset 0 so the closest
  // requester to start_i is the last (winning) assignment.
  always_comb begin
    int k;
    k       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      k = (int'(start_i) + i) % NUM_UNITS;
      if (req_i[k]) begin
        found_o = 1'b1;
        idx_o   = UNIT_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: grants up to two finished execution-unit results per cycle
// to the two register-file write ports.
//
// Handshake: a unit holds <u>_done=1 with stable rd/data until it sees
// <u>_ack=1 (combinational, same cycle); after that cycle it drops or
// replaces the result. A granted result appears on wrN_* one edge later.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   <u>_done/_rd/_data       unit results (alu1, alu2, advint, memunit, branch)
//   advint_rd2/_data2        advint second result (rd2=0: none)
//   <u>_ack                  grant back to each unit
//   wr1_*/wr2_*              registered register-file write ports
//   reg1/2_finished          write register number when enabled, else 0
//   dbg_ptr_o                current priority pointer
//
// Configuration: define WB_ROUND_ROBIN_EN to rotate the priority pointer
// past the last granted unit; otherwise priority is static with alu1 highest.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu1_done,
  input  logic [RN_W-1:0]   alu1_rd,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic              alu2_done,
  input  logic [RN_W-1:0]   alu2_rd,
  input  logic [DATA_W-1:0] alu2_data,
  input  logic              advint_done,
  input  logic [RN_W-1:0]   advint_rd,
  input  logic [DATA_W-1:0] advint_data,
  input  logic [RN_W-1:0]   advint_rd2,
  input  logic [DATA_W-1:0] advint_data2,
  input  logic              memunit_done,
  input  logic [RN_W-1:0]   memunit_rd,
  input  logic [DATA_W-1:0] memunit_data,
  input  logic              branch_done,
  input  logic [RN_W-1:0]   branch_rd,
  input  logic [DATA_W-1:0] branch_data,
  output logic              alu1_ack,
  output logic              alu2_ack,
  output logic              advint_ack,
  output logic              memunit_ack,
  output logic              branch_ack,
  output logic              wr1_en,
  output logic [RN_W-1:0]   wr1_rn,
  output logic [DATA_W-1:0] wr1_data,
  output logic              wr2_en,
  output logic [RN_W-1:0]   wr2_rn,
  output logic [DATA_W-1:0] wr2_data,
  output logic [RN_W-1:0]   reg1_finished,
  output logic [RN_W-1:0]   reg2_finished,
  output logic [UNIT_W-1:0] dbg_ptr_o
);

  logic [NUM_UNITS-1:0] req, req_b, gnt;
  logic [RN_W-1:0]      rd_arr   [NUM_UNITS];
  logic [DATA_W-1:0]    data_arr [NUM_UNITS];

  assign req = {branch_done, memunit_done, advint_done, alu2_done, alu1_done};
  assign rd_arr   = '{alu1_rd, alu2_rd, advint_rd, memunit_rd, branch_rd};
  assign data_arr = '{alu1_data, alu2_data, advint_data, memunit_data, branch_data};

  logic [UNIT_W-1:0] ptr_q, ptr_d;
  logic              a_found, b_found;
  logic [UNIT_W-1:0] a_idx, b_idx;
  logic              adv_dual, a_dual, b_ok;

  // advint carrying two results needs both ports, so it may only win grant A.
  assign adv_dual = advint_done && (advint_rd2 != '0);

  rr_picker u_pick_a (
    .req_i   (req),
    .start_i (ptr_q),
    .found_o (a_found),
    .idx_o   (a_idx)
  );

  always_comb begin
    req_b        = req;
    req_b[a_idx] = 1'b0;
    if (adv_dual) req_b[ADVINT] = 1'b0;
  end

  rr_picker u_pick_b (
    .req_i   (req_b),
    .start_i (next_unit(a_idx)),
    .found_o (b_found),
    .idx_o   (b_idx)
  );

  assign a_dual = a_found && (a_idx == ADVINT) && adv_dual;

  // Grant B is withheld when it would write the same nonzero register as A.
  assign b_ok = a_found && !a_dual && b_found &&
                !((rd_arr[b_idx] != '0) && (rd_arr[b_idx] == rd_arr[a_idx]));

  assign gnt = (a_found ? (5'd1 << a_idx) : 5'd0) | (b_ok ? (5'd1 << b_idx) : 5'd0);

  assign {branch_ack, memunit_ack, advint_ack, alu2_ack, alu1_ack} = rst ? '0 : gnt;

  // Write-port next state.
  logic              wr1_en_q, wr1_en_d, wr2_en_q, wr2_en_d;
  logic [RN_W-1:0]   wr1_rn_q, wr1_rn_d, wr2_rn_q, wr2_rn_d;
  logic [DATA_W-1:0] wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;

  always_comb begin
    wr1_en_d   = 1'b0;
    wr1_rn_d   = '0;
    wr1_data_d = '0;
    wr2_en_d   = 1'b0;
    wr2_rn_d   = '0;
    wr2_data_d = '0;
    // A granted rd=0 result is acked but leaves its port idle.
    if (a_found && (rd_arr[a_idx] != '0)) begin
      wr1_en_d   = 1'b1;
      wr1_rn_d   = rd_arr[a_idx];
      wr1_data_d = data_arr[a_idx];
    end
    if (a_dual) begin
      wr2_en_d   = 1'b1;
      wr2_rn_d   = advint_rd2;
      wr2_data_d = advint_data2;
    end else if (b_ok && (rd_arr[b_idx] != '0)) begin
      wr2_en_d   = 1'b1;
      wr2_rn_d   = rd_arr[b_idx];
      wr2_data_d = data_arr[b_idx];
    end
  end

  // Pointer next state.
`ifdef WB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (b_ok)         ptr_d = next_unit(b_idx);
    else if (a_found) ptr_d = next_unit(a_idx);
  end
`else
  assign ptr_d = ALU1;
`endif

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= ALU1;
      wr1_en_q   <= 1'b0;
      wr1_rn_q   <= '0;
      wr1_data_q <= '0;
      wr2_en_q   <= 1'b0;
      wr2_rn_q   <= '0;
      wr2_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr1_en_q   <= wr1_en_d;
      wr1_rn_q   <= wr1_rn_d;
      wr1_data_q <= wr1_data_d;
      wr2_en_q   <= wr2_en_d;
      wr2_rn_q   <= wr2_rn_d;
      wr2_data_q <= wr2_data_d;
    end
  end

  // Outputs.
  assign wr1_en        = wr1_en_q;
  assign wr1_rn        = wr1_rn_q;
  assign wr1_data      = wr1_data_q;
  assign wr2_en        = wr2_en_q;
  assign wr2_rn        = wr2_rn_q;
  assign wr2_data      = wr2_data_q;
  assign reg1_finished = wr1_en_q ? wr1_rn_q : '0;
  assign reg2_finished = wr2_en_q ? wr2_rn_q : '0;
  assign dbg_ptr_o     = ptr_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports `clk` and `rst` are listed first.
REQ-002 `clk`  in  1  rising-edge clock for all state.
REQ-003 `rst`  in  1  synchronous active-high reset.
REQ-004 `<u>_done`  in  1  unit result valid, for u in alu1, alu2, advint, memunit, branch; held until acked.
REQ-005 `<u>_rd`  in  6  destination register number, for each u.
REQ-006 `<u>_data`  in  64  result value, for each u.
REQ-007 `advint_rd2`  in  6  second destination register number; 0 means none.
REQ-008 `advint_data2`  in  64  second result value.
REQ-009 `<u>_ack`  out  1  combinational grant; the unit drops or replaces its result after the cycle in which ack is high.
REQ-010 `wr1_en` / `wr2_en`  out  1 each  registered register-file write enables.
REQ-011 `wr1_rn` / `wr2_rn`  out  6 each  registered write register numbers.
REQ-012 `wr1_data` / `wr2_data`  out  64 each  registered write data.
REQ-013 `reg1_finished` / `reg2_finished`  out  6 each  equal to `wrN_rn` when `wrN_en`=1, else 0; these feed the scheduler.

Function
REQ-014 Per cycle, at most two results SHALL be granted: grant A goes to port 1, grant B to port 2.
REQ-015 Grant A SHALL be the first requesting unit at or after the priority pointer, in order alu1, alu2, advint, memunit, branch, wrapping around.
REQ-016 Grant B SHALL be the next requesting unit after grant A in that same order, wrapping around; grant B never equals grant A.
REQ-017 advint with `advint_done`=1 and `advint_rd2`≠0 SHALL be granted only as grant A:
- it takes both ports (`rd` on port 1, `rd2` on port 2);
- no grant B is issued that cycle;
- if it would be grant B, it waits.
REQ-018 If grant B has the same nonzero rd as grant A, grant B SHALL be withheld that cycle (WAW guard).
REQ-019 A granted request SHALL produce `wrN_*` outputs on the next rising edge (one-cycle latency); ungranted ports drive en=0, rn=0, data=0.
REQ-020 A granted result with rd=0 SHALL be acked and consume its port, with `wrN_en`=0.
REQ-021 `<u>_ack` SHALL be high only while `<u>_done`=1 and `rst`=0.
REQ-022 The pointer SHALL move to the unit after the last granted unit (grant B if issued, else grant A); with no grant it holds.
REQ-023 With no request, all write outputs SHALL be 0 next cycle.

Reset
REQ-024 While `rst`=1:
- all acks are 0;
- at the next edge all `wr*` and `reg*_finished` outputs clear to 0;
- the pointer resets to alu1.
REQ-025 Asserting `rst` mid-operation SHALL discard any pending registered write; unacked unit results remain held by their units.

Configuration
REQ-026 With `WB_ROUND_ROBIN_EN` defined, the pointer SHALL behave as in REQ-022.
REQ-027 Without `WB_ROUND_ROBIN_EN`, the pointer SHALL be fixed at alu1 (static priority alu1 > alu2 > advint > memunit > branch); all other rules are unchanged.

Structure
REQ-028 A shared package SHALL hold:
- the unit index constants (ALU1=0 … BRANCH=4);
- `NUM_UNITS`=5;
- the register-number width 6;
- the data width 64.
REQ-029 One sub-module `rr_picker` SHALL return the first set bit of a 5-bit request vector at or after a start index, wrapping around; it is instantiated twice (grants A and B).

Verification
REQ-030 alu1 and memunit both request (rd=5, rd=9), pointer at alu1 -> both acked the same cycle; next cycle `wr1_rn`=5 and `wr2_rn`=9, `reg1_finished`=5, `reg2_finished`=9.
REQ-031 All five units request continuously, round-robin enabled -> grants rotate (alu1,alu2), (advint,memunit), (branch,alu1)…; no unit starves beyond 3 cycles.
REQ-032 advint requests with rd=3, rd2=7 while the pointer is at alu1 and alu1 requests -> cycle 1 grants alu1 only; cycle 2 grants advint on both ports (3, 7).
REQ-033 alu2 and branch both request with rd=12 -> only one is acked; the other is written in the following cycle.
REQ-034 memunit requests with rd=0 -> memunit is acked; next cycle `wr1_en`=0 and `reg1_finished`=0.
REQ-035 Assert `rst` in the cycle after a grant -> `wr*` outputs are 0 at the next edge, no ack is asserted during `rst`, and after release grants restart from alu1.
